// File: rtl/apu_pkg.sv
// Shared constants for the APU I/O page: SMP nibble decode and CONTROL bit layout.
package apu_pkg;

    localparam logic [3:0] SMP_CONTROL = 4'h1;
    localparam logic [3:0] SMP_PORT0   = 4'h4;
    localparam logic [3:0] SMP_PORT1   = 4'h5;
    localparam logic [3:0] SMP_PORT2   = 4'h6;
    localparam logic [3:0] SMP_PORT3   = 4'h7;

    localparam int unsigned CTL_IPL   = 7;
    localparam int unsigned CTL_CLR23 = 5;
    localparam int unsigned CTL_CLR01 = 4;
    localparam int unsigned CTL_T2    = 2;
    localparam int unsigned CTL_T1    = 1;
    localparam int unsigned CTL_T0    = 0;

    // Bits that go from 0 to 1 between the old and new timer enables.
    function automatic logic [2:0] rising_bits(input logic [2:0] old_v, input logic [2:0] new_v);
        return new_v & ~old_v;
    endfunction

endpackage

// File: rtl/apu_port_latch.sv
// One 8-bit mailbox register: write beats clear, synchronous reset beats both.
module apu_port_latch
    import apu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr,
    input  logic       clr,
    input  logic [7:0] wdata,
    output logic [7:0] q
);

    logic [7:0] data_d;
    logic [7:0] data_q;

    // Next-value select: write data, cleared, or hold.
    always_comb begin
        data_d = data_q;
        if (wr) begin
            data_d = wdata;
        end else if (clr) begin
            data_d = 8'h00;
        end else begin
            data_d = data_q;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= 8'h00;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/apu_io_ports.sv
// S-CPU <-> SPC700 mailbox ports plus the CONTROL register ($F1) driving IPL overlay and timers.
module apu_io_ports
    import apu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] cpu_addr,
    input  logic       cpu_rd,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    input  logic [3:0] smp_addr,
    input  logic       smp_rd,
    input  logic       smp_wr,
    input  logic [7:0] smp_wdata,
    output logic [7:0] smp_rdata,
    output logic       ipl_en,
    output logic [2:0] timer_en,
    output logic [2:0] timer_restart
);

    logic [7:0] c2s_s [4];
    logic [7:0] s2c_s [4];
    logic [3:0] c2s_wr_s;
    logic [3:0] c2s_clr_s;
    logic [3:0] s2c_wr_s;
    logic       ctl_wr_s;

    logic [7:0] cpu_rdata_d, cpu_rdata_q;
    logic [7:0] smp_rdata_d, smp_rdata_q;
    logic       ipl_en_d, ipl_en_q;
    logic [2:0] timer_en_d, timer_en_q;
    logic [2:0] timer_restart_d, timer_restart_q;

    // Strobe decode for both buses.
    always_comb begin
        ctl_wr_s     = smp_wr && (smp_addr == SMP_CONTROL);
        c2s_clr_s[0] = ctl_wr_s && smp_wdata[CTL_CLR01];
        c2s_clr_s[1] = ctl_wr_s && smp_wdata[CTL_CLR01];
        c2s_clr_s[2] = ctl_wr_s && smp_wdata[CTL_CLR23];
        c2s_clr_s[3] = ctl_wr_s && smp_wdata[CTL_CLR23];
        for (int i = 0; i < 4; i++) begin
            c2s_wr_s[i] = cpu_wr && (cpu_addr == 2'(i));
            s2c_wr_s[i] = smp_wr && (smp_addr == (SMP_PORT0 + 4'(i)));
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_ports
        apu_port_latch u_c2s (
            .clk   (clk),
            .reset (reset),
            .wr    (c2s_wr_s[g]),
            .clr   (c2s_clr_s[g]),
            .wdata (cpu_wdata),
            .q     (c2s_s[g])
        );
        apu_port_latch u_s2c (
            .clk   (clk),
            .reset (reset),
            .wr    (s2c_wr_s[g]),
            .clr   (1'b0),
            .wdata (smp_wdata),
            .q     (s2c_s[g])
        );
    end

    // Read muxes (pre-edge latch values, so same-cycle writes are not visible) and CONTROL next state.
    always_comb begin
        cpu_rdata_d     = cpu_rdata_q;
        smp_rdata_d     = smp_rdata_q;
        ipl_en_d        = ipl_en_q;
        timer_en_d      = timer_en_q;
        timer_restart_d = 3'b000;
        if (cpu_rd) begin
            cpu_rdata_d = s2c_s[cpu_addr];
        end else begin
            cpu_rdata_d = cpu_rdata_q;
        end
        if (smp_rd) begin
            case (smp_addr)
                SMP_PORT0: smp_rdata_d = c2s_s[0];
                SMP_PORT1: smp_rdata_d = c2s_s[1];
                SMP_PORT2: smp_rdata_d = c2s_s[2];
                SMP_PORT3: smp_rdata_d = c2s_s[3];
                default:   smp_rdata_d = 8'h00;
            endcase
        end else begin
            smp_rdata_d = smp_rdata_q;
        end
        if (ctl_wr_s) begin
            ipl_en_d        = smp_wdata[CTL_IPL];
            timer_en_d      = {smp_wdata[CTL_T2], smp_wdata[CTL_T1], smp_wdata[CTL_T0]};
            timer_restart_d = rising_bits(timer_en_q, timer_en_d);
        end else begin
            ipl_en_d        = ipl_en_q;
            timer_en_d      = timer_en_q;
            timer_restart_d = 3'b000;
        end
    end

    // Output and control registers; reset overrides every strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdata_q     <= 8'h00;
            smp_rdata_q     <= 8'h00;
            ipl_en_q        <= 1'b1;
            timer_en_q      <= 3'b000;
            timer_restart_q <= 3'b000;
        end else begin
            cpu_rdata_q     <= cpu_rdata_d;
            smp_rdata_q     <= smp_rdata_d;
            ipl_en_q        <= ipl_en_d;
            timer_en_q      <= timer_en_d;
            timer_restart_q <= timer_restart_d;
        end
    end

    assign cpu_rdata     = cpu_rdata_q;
    assign smp_rdata     = smp_rdata_q;
    assign ipl_en        = ipl_en_q;
    assign timer_en      = timer_en_q;
    assign timer_restart = timer_restart_q;

endmodule

// File: tb/tb_apu_io_ports.sv
// Directed test-plan steps followed by random traffic, all checked against a mailbox model.
module tb_apu_io_ports;

    logic       clk;
    logic       reset;
    logic [1:0] cpu_addr;
    logic       cpu_rd;
    logic       cpu_wr;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic [3:0] smp_addr;
    logic       smp_rd;
    logic       smp_wr;
    logic [7:0] smp_wdata;
    logic [7:0] smp_rdata;
    logic       ipl_en;
    logic [2:0] timer_en;
    logic [2:0] timer_restart;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] m_c2s [4];
    logic [7:0] m_s2c [4];
    logic [7:0] m_cpu_rdata;
    logic [7:0] m_smp_rdata;
    logic       m_ipl;
    logic [2:0] m_ten;
    logic [2:0] m_pulse;

    apu_io_ports dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_addr      (cpu_addr),
        .cpu_rd        (cpu_rd),
        .cpu_wr        (cpu_wr),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .smp_addr      (smp_addr),
        .smp_rd        (smp_rd),
        .smp_wr        (smp_wr),
        .smp_wdata     (smp_wdata),
        .smp_rdata     (smp_rdata),
        .ipl_en        (ipl_en),
        .timer_en      (timer_en),
        .timer_restart (timer_restart)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock given this cycle's inputs.
    task automatic model_step(input logic rst, input logic crd, input logic cwr, input logic [1:0] ca,
                              input logic [7:0] cwd, input logic srd, input logic swr,
                              input logic [3:0] sa, input logic [7:0] swd);
        logic [7:0] nc2s [4];
        logic [7:0] ns2c [4];
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_c2s[i] = 8'h00;
                m_s2c[i] = 8'h00;
            end
            m_cpu_rdata = 8'h00;
            m_smp_rdata = 8'h00;
            m_ipl       = 1'b1;
            m_ten       = 3'b000;
            m_pulse     = 3'b000;
            return;
        end
        nc2s = m_c2s;
        ns2c = m_s2c;
        if (crd) m_cpu_rdata = m_s2c[ca];
        if (srd) m_smp_rdata = (sa >= 4'd4 && sa <= 4'd7) ? m_c2s[sa - 4'd4] : 8'h00;
        m_pulse = 3'b000;
        if (swr && sa == 4'd1) begin
            m_pulse = swd[2:0] & ~m_ten;
            m_ten   = swd[2:0];
            m_ipl   = swd[7];
            if (swd[4]) begin nc2s[0] = 8'h00; nc2s[1] = 8'h00; end
            if (swd[5]) begin nc2s[2] = 8'h00; nc2s[3] = 8'h00; end
        end
        if (swr && sa >= 4'd4 && sa <= 4'd7) ns2c[sa - 4'd4] = swd;
        if (cwr) nc2s[ca] = cwd;
        m_c2s = nc2s;
        m_s2c = ns2c;
    endtask

    task automatic cyc(input logic rst, input logic crd, input logic cwr, input logic [1:0] ca,
                       input logic [7:0] cwd, input logic srd, input logic swr,
                       input logic [3:0] sa, input logic [7:0] swd);
        reset = rst; cpu_rd = crd; cpu_wr = cwr; cpu_addr = ca; cpu_wdata = cwd;
        smp_rd = srd; smp_wr = swr; smp_addr = sa; smp_wdata = swd;
        model_step(rst, crd, cwr, ca, cwd, srd, swr, sa, swd);
        @(posedge clk);
        #1;
        reset = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; smp_rd = 1'b0; smp_wr = 1'b0;
        chk("cpu_rdata", cpu_rdata, m_cpu_rdata);
        chk("smp_rdata", smp_rdata, m_smp_rdata);
        chk("ipl_en", {7'd0, ipl_en}, {7'd0, m_ipl});
        chk("timer_en", {5'd0, timer_en}, {5'd0, m_ten});
        chk("timer_restart", {5'd0, timer_restart}, {5'd0, m_pulse});
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        cyc(1'b0, 1'b0, 1'b1, a, d, 1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic smp_write(input logic [3:0] a, input logic [7:0] d);
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, a, d);
    endtask

    task automatic read_both(input logic [1:0] ca, input logic [3:0] sa);
        cyc(1'b0, 1'b1, 1'b0, ca, 8'h00, 1'b1, 1'b0, sa, 8'h00);
    endtask

    initial begin
        reset = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 2'd0; cpu_wdata = 8'h00;
        smp_rd = 1'b0; smp_wr = 1'b0; smp_addr = 4'h0; smp_wdata = 8'h00;
        for (int i = 0; i < 4; i++) begin m_c2s[i] = 8'h00; m_s2c[i] = 8'h00; end
        m_cpu_rdata = 8'h00; m_smp_rdata = 8'h00; m_ipl = 1'b1; m_ten = 3'b000; m_pulse = 3'b000;

        // Reset values
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        read_both(2'd2, 4'h5);
        chk("rst_cpu_p2", cpu_rdata, 8'h00);
        chk("rst_smp_f5", smp_rdata, 8'h00);
        chk("rst_ipl", {7'd0, ipl_en}, 8'h01);
        chk("rst_ten", {5'd0, timer_en}, 8'h00);

        // Mailbox path
        cpu_write(2'd0, 8'hCC);
        read_both(2'd0, 4'h4);
        chk("c2s0_cc", smp_rdata, 8'hCC);
        smp_write(4'h4, 8'hAA);
        smp_write(4'h5, 8'hBB);
        read_both(2'd0, 4'h0);
        chk("s2c0_aa", cpu_rdata, 8'hAA);
        read_both(2'd1, 4'h0);
        chk("s2c1_bb", cpu_rdata, 8'hBB);

        // Same-cycle write and read returns old value
        cyc(1'b0, 1'b0, 1'b1, 2'd0, 8'h77, 1'b1, 1'b0, 4'h4, 8'h00);
        chk("old_on_collide", smp_rdata, 8'hCC);

        // CONTROL clear
        cpu_write(2'd0, 8'h11); cpu_write(2'd1, 8'h22); cpu_write(2'd2, 8'h33); cpu_write(2'd3, 8'h44);
        smp_write(4'h4, 8'h55); smp_write(4'h5, 8'h66); smp_write(4'h6, 8'h77); smp_write(4'h7, 8'h88);
        smp_write(4'h1, 8'h30);
        chk("clr_ipl", {7'd0, ipl_en}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            read_both(2'(i), 4'h4 + 4'(i));
            chk("clr_c2s", smp_rdata, 8'h00);
            chk("keep_s2c", cpu_rdata, 8'h55 + 8'(i) * 8'h11);
        end
        read_both(2'd0, 4'h1);
        chk("f1_reads_zero", smp_rdata, 8'h00);

        // Clear vs write
        cpu_write(2'd0, 8'h12);
        cyc(1'b0, 1'b0, 1'b1, 2'd1, 8'h5A, 1'b0, 1'b1, 4'h1, 8'h90);
        chk("cw_ipl", {7'd0, ipl_en}, 8'h01);
        read_both(2'd0, 4'h4);
        chk("cw_c2s0", smp_rdata, 8'h00);
        read_both(2'd0, 4'h5);
        chk("cw_c2s1", smp_rdata, 8'h5A);

        // Timer pulses
        smp_write(4'h1, 8'h81);
        chk("tr_001", {5'd0, timer_restart}, 8'h01);
        idle();
        chk("tr_001_off", {5'd0, timer_restart}, 8'h00);
        smp_write(4'h1, 8'h83);
        chk("tr_010", {5'd0, timer_restart}, 8'h02);
        idle();
        smp_write(4'h1, 8'h83);
        chk("tr_none", {5'd0, timer_restart}, 8'h00);

        // Reset mid-operation
        smp_write(4'h4, 8'h9C);
        cyc(1'b1, 1'b0, 1'b1, 2'd3, 8'hFF, 1'b0, 1'b1, 4'h1, 8'h05);
        chk("mr_ipl", {7'd0, ipl_en}, 8'h01);
        chk("mr_ten", {5'd0, timer_en}, 8'h00);
        chk("mr_tr", {5'd0, timer_restart}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            read_both(2'(i), 4'h4 + 4'(i));
            chk("mr_c2s", smp_rdata, 8'h00);
            chk("mr_s2c", cpu_rdata, 8'h00);
        end

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [3:0] sa;
            logic [7:0] swd;
            sa  = ($urandom_range(0, 3) == 0) ? 4'h1 : 4'($urandom_range(0, 15));
            swd = 8'($urandom);
            cyc(($urandom_range(0, 60) == 0), 1'($urandom), 1'($urandom), 2'($urandom),
                8'($urandom), 1'($urandom), 1'($urandom), sa, swd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
